// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation codes,
// iterative-engine state encoding and the default datapath width.
package mips_pkg;

  // Default operand / HI / LO width.
  localparam int MD_WIDTH = 32;

  // Multiply/divide operation codes presented on the op input.
  // 3'b110 and 3'b111 are reserved and behave as no-ops.
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_t;

  // Iterative engine states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } md_state_t;

  // True for the four multi-cycle operations (MULT, MULTU, DIV, DIVU).
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  // True for the signed variants; their operands are converted to magnitudes.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // True for the register-move operations that complete in one cycle.
  function automatic logic is_move_op(input logic [2:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration of the multiply/divide engine. Both modes run through
// the same (WIDTH+1)-bit adder: multiply adds the multiplicand into the high
// half when the current multiplier bit is set, divide subtracts the divisor
// from the shifted partial remainder and restores it on a borrow.
module md_iter_step
  #(parameter int WIDTH = 32)
  (
    input  logic [WIDTH-1:0] i_acc_hi,   // product high half / partial remainder
    input  logic [WIDTH-1:0] i_acc_lo,   // multiplier bits / dividend-quotient bits
    input  logic [WIDTH-1:0] i_operand,  // multiplicand or divisor magnitude
    input  logic             i_is_div,   // 1: divide step, 0: multiply step
    output logic [WIDTH-1:0] o_next_hi,
    output logic [WIDTH-1:0] o_next_lo,  // divide mode leaves the LSB clear for o_q_bit
    output logic             o_q_bit
  );

  logic [WIDTH:0] w_a;
  logic [WIDTH:0] w_b;
  logic [WIDTH:0] w_res;

  // Shared add/subtract and per-mode shift of the accumulator pair.
  always_comb begin
    w_a       = '0;
    w_b       = '0;
    w_res     = '0;
    o_next_hi = i_acc_hi;
    o_next_lo = i_acc_lo;
    o_q_bit   = 1'b0;
    if (i_is_div) begin
      // Partial remainder is always below the divisor, so the shifted value
      // fits in WIDTH+1 bits and the top result bit is a clean borrow flag.
      w_a       = {i_acc_hi, i_acc_lo[WIDTH-1]};
      w_b       = ~{1'b0, i_operand};
      w_res     = w_a + w_b + {{WIDTH{1'b0}}, 1'b1};
      o_q_bit   = ~w_res[WIDTH];
      o_next_hi = o_q_bit ? w_res[WIDTH-1:0] : w_a[WIDTH-1:0];
      o_next_lo = {i_acc_lo[WIDTH-2:0], 1'b0};
    end else begin
      w_a       = {1'b0, i_acc_hi};
      w_b       = i_acc_lo[0] ? {1'b0, i_operand} : '0;
      w_res     = w_a + w_b;
      o_next_hi = w_res[WIDTH:1];
      o_next_lo = {w_res[0], i_acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO
// registers. MULT/MULTU/DIV/DIVU occupy the engine for WIDTH CALC cycles plus
// one FIX cycle; MTHI/MTLO write HI/LO directly in a single cycle.
//
// Issue handshake: start is a one-cycle request sampled on the rising edge.
// It is accepted only while busy is low; there is no back-pressure, so a
// start presented while busy is dropped without any side effect. done (and
// divByZero for a zero divisor) pulse for exactly one cycle when HI/LO take
// an iterative result; busy is already low in that cycle, so a new start may
// be issued alongside done.
module mult_div_unit
  import mips_pkg::*;
  #(parameter int WIDTH = MD_WIDTH)
  (
    input  logic             clk,
    input  logic             rst,         // synchronous, active low
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       o_dbg_state  // current engine state (md_state_t)
  );

  localparam int CW = $clog2(WIDTH);

  md_state_t        r_state;
  md_state_t        w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_operand;
  logic             r_is_div;
  logic             r_neg_main;   // negate product, or negate quotient
  logic             r_neg_rem;    // negate remainder
  logic             r_div0;
  logic [WIDTH-1:0] r_opa_raw;    // original dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz;

  logic             w_idle;
  logic             w_accept;
  logic             w_move;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic             w_step_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && start && is_iter_op(op);
  assign w_move   = w_idle && start && is_move_op(op);

  assign w_sign_a = is_signed_op(op) && opA[WIDTH-1];
  assign w_sign_b = is_signed_op(op) && opB[WIDTH-1];
  assign w_mag_a  = w_sign_a ? (~opA + {{(WIDTH-1){1'b0}}, 1'b1}) : opA;
  assign w_mag_b  = w_sign_b ? (~opB + {{(WIDTH-1){1'b0}}, 1'b1}) : opB;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_acc_hi  (r_acc_hi),
    .i_acc_lo  (r_acc_lo),
    .i_operand (r_operand),
    .i_is_div  (r_is_div),
    .o_next_hi (w_step_hi),
    .o_next_lo (w_step_lo),
    .o_q_bit   (w_step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> CALC on an accepted iterative op, CALC runs
  // until the counter reaches zero, FIX always returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_CALC;
      ST_CALC: if (r_cnt == '0) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand capture on issue and one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_operand  <= '0;
      r_is_div   <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div0     <= 1'b0;
      r_opa_raw  <= '0;
    end else if (w_accept) begin
      // op[1] separates divide from multiply among the iterative codes.
      r_cnt      <= CW'(WIDTH - 1);
      r_acc_hi   <= '0;
      r_acc_lo   <= op[1] ? w_mag_a : w_mag_b;
      r_operand  <= op[1] ? w_mag_b : w_mag_a;
      r_is_div   <= op[1];
      r_neg_main <= w_sign_a ^ w_sign_b;
      r_neg_rem  <= w_sign_a;
      r_div0     <= op[1] && (opB == '0);
      r_opa_raw  <= opA;
    end else if (r_state == ST_CALC) begin
      r_cnt    <= r_cnt - CW'(1);
      r_acc_hi <= w_step_hi;
      // The quotient bit enters at the LSB vacated by the divide shift.
      r_acc_lo <= w_step_lo | {{(WIDTH-1){1'b0}}, w_step_q};
    end
  end

  // Sign correction and divide-by-zero substitution applied in FIX.
  always_comb begin
    w_prod   = {r_acc_hi, r_acc_lo};
    w_res_hi = r_acc_hi;
    w_res_lo = r_acc_lo;
    if (r_is_div) begin
      if (r_div0) begin
        w_res_hi = r_opa_raw;
        w_res_lo = '1;
      end else begin
        w_res_lo = r_neg_main ? (~r_acc_lo + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc_lo;
        w_res_hi = r_neg_rem  ? (~r_acc_hi + {{(WIDTH-1){1'b0}}, 1'b1}) : r_acc_hi;
      end
    end else begin
      if (r_neg_main) w_prod = ~w_prod + {{(2*WIDTH-1){1'b0}}, 1'b1};
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  // HI/LO architectural registers and the done / divByZero pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (r_state == ST_FIX) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
        r_dbz  <= r_div0;
      end else if (w_move) begin
        if (op == MD_MTHI) r_hi <= opA;
        else               r_lo <= opA;
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign divByZero   = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule
